// File: rtl/mult_div_seq_if.sv
// Handshake and data bundle between the control unit and the multiply/divide unit.
interface mult_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Control unit side: issues requests and consumes HI/LO.
    modport master (
        output start, op, src_a, src_b,
        input  hi_out, lo_out, busy, done, div_zero
    );

    // Unit side.
    modport slave (
        input  start, op, src_a, src_b,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_seq.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes).
// One bit per cycle; HI/LO load in FIN, done pulses the cycle after.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mult_div_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN, DZ} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH:0]   acc_q, acc_d;      // Booth accumulator / partial remainder
    logic [WIDTH-1:0] qr_q, qr_d;        // multiplier Q / dividend-quotient shifter
    logic             q1_q, q1_d;        // Booth q-1 bit
    logic [WIDTH-1:0] m_q, m_d;          // multiplicand / divisor magnitude
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] abs_a, abs_b, rem_mag;
    logic [WIDTH:0]   m_ext, booth_sum, div_shift, div_trial;

    // Next-state, iteration datapath and result formatting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        q1_d      = q1_q;
        m_d       = m_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        abs_a   = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
        abs_b   = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
        rem_mag = acc_q[WIDTH-1:0];

        m_ext = {m_q[WIDTH-1], m_q};
        case ({qr_q[0], q1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase

        // Remainder stays below the divisor, so the top acc bit is always zero here.
        div_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    acc_d = '0;
                    q1_d  = 1'b0;
                    cnt_d = '0;
                    if (bus.op) begin
                        qr_d      = abs_a;
                        m_d       = abs_b;
                        quo_neg_d = bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
                        rem_neg_d = bus.src_a[WIDTH-1];
                        state_d   = (bus.src_b == '0) ? DZ : CALC;
                    end else begin
                        qr_d      = bus.src_a;
                        m_d       = bus.src_b;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q) begin
                    if (!div_trial[WIDTH]) begin
                        acc_d = div_trial;
                        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Arithmetic shift right of {acc, Q, q-1}.
                    {acc_d, qr_d, q1_d} = {booth_sum[WIDTH], booth_sum, qr_q};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (op_q) begin
                    hi_d = rem_neg_q ? -rem_mag : rem_mag;
                    lo_d = quo_neg_q ? -qr_q : qr_q;
                end else begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = qr_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DZ: begin
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= 1'b0;
            acc_q     <= '0;
            qr_q      <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            qr_q      <= qr_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Multicycle signed multiply/divide unit for the CPU. It produces HI/LO for MULT/DIV.
- The control unit issues a one-cycle start with the operation select. Operands come from the A/B registers.
- The unit iterates one bit per cycle and pulses done when HI/LO are valid for the HI/LO register write.
- It flags divide-by-zero so the control unit can take the Div0 exception path.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV
src_a  input  WIDTH  multiplicand / dividend (two's complement)
src_b  input  WIDTH  multiplier / divisor (two's complement)
hi_out  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo_out  output  WIDTH  MULT: product[W-1:0]; DIV: quotient
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; hi_out/lo_out valid from this cycle
div_zero  output  1  one-cycle pulse with done when DIV had src_b == 0

Behaviour:
- Reset: state IDLE, counter 0, all internal regs 0; hi_out = lo_out = 0; busy = done = div_zero = 0.
- Reset mid-operation aborts immediately; the same values apply at the next edge.
- States: IDLE, CALC, FIN, DZ.
- IDLE, start=1: latch op, src_a, src_b.
  - If op=1 and src_b==0: go to DZ.
  - Otherwise: go to CALC, counter=0.
- IDLE, start=0: stay.
- CALC:
  - Perform one iteration per edge and increment the counter.
  - On the edge where counter == WIDTH-1 completes: go to FIN.
  - start is ignored throughout.
- FIN: on its edge, load hi_out/lo_out, assert done for the next cycle, go to IDLE.
- DZ: on its edge, assert done and div_zero for the next cycle, go to IDLE. hi_out/lo_out are unchanged.
- Latency, counting the start edge as edge 1:
  - Normal op: done high in the cycle after edge WIDTH+2 (34 at default).
  - Div-by-zero: done high in the cycle after edge 2.
- busy rises after edge 1 and falls in the same cycle done is high.
- done and div_zero are high exactly one cycle. They are deasserted on the next edge regardless of start.
- hi_out/lo_out hold their values until the next FIN or reset.
- MULT:
  - Radix-2 Booth algorithm.
  - Accumulator is WIDTH+1 bits with arithmetic right shift of {acc, Q, q-1}.
  - Result is the exact signed 2*WIDTH product; no overflow.
- DIV:
  - Restoring division on magnitudes |src_a|, |src_b|.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Corner case: src_a = 0x80000000, src_b = -1 gives lo_out = 0x80000000 (wrap) and hi_out = 0. No flag is raised.
- Back-to-back: start high in the same cycle done is high is accepted, because the state is IDLE in that cycle. The new operation's done then follows after the full latency.

Test Plan:
- Reset, then MULT 7 * -3 with start at edge 1:
  - busy=1 during edges 2..34.
  - done=1 in exactly one cycle after edge 34.
  - hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- MULT 0x80000000 * 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000. Also 0xFFFFFFFF * 0xFFFFFFFF -> hi_out=0, lo_out=1.
- DIV cases:
  - -7 / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
  - 7 / -2 -> lo_out=0xFFFFFFFD, hi_out=0x00000001.
  - 0x80000000 / -1 -> lo_out=0x80000000, hi_out=0.
- DIV 5 / 0 after a previous MULT left hi_out=0x12, lo_out=0x34:
  - done=div_zero=1 in the cycle after edge 2.
  - hi_out/lo_out stay 0x12/0x34.
- Busy and back-to-back handling:
  - start pulses with different operands at edges 5 and 20 of an active MULT are ignored; the result matches the first operands.
  - start held high during the done cycle launches a second op; its done appears 34 cycles later.
- Assert reset at edge 15 of a DIV:
  - The next cycle shows busy=done=div_zero=0 and hi_out=lo_out=0.
  - No done appears afterwards until a new start.
